// File: rtl/view_serializer_pkg.sv
// Shared frame layout, FSM state encoding and frame packing for the view serializer.
package view_serializer_pkg;

  localparam int FRAME_W     = 26;
  localparam int OUTVIEW_LSB = 0;
  localparam int L1_LSB      = 18;
  localparam int L2_LSB      = 22;
  localparam int BITCNT_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4,
    ST_GAP      = 3'd5
  } state_e;

  function automatic logic [FRAME_W-1:0] pack_frame(input logic [3:0]  l2,
                                                    input logic [3:0]  l1,
                                                    input logic [17:0] ov);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[L2_LSB +: 4]       = l2;
    f[L1_LSB +: 4]       = l1;
    f[OUTVIEW_LSB +: 18] = ov;
    return f;
  endfunction

endpackage

// File: rtl/view_ser_tick.sv
// Phase counter: counts clk cycles spent in the current FSM state and flags the last one.
module view_ser_tick #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] term,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == term);

endmodule

// File: rtl/view_serializer.sv
// Snapshots {light_2, light_1, outview} each frame and shifts it MSB-first to an LED shift-register chain.
module view_serializer
  import view_serializer_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [17:0] outview,
  input  logic [3:0]  light_1,
  input  logic [3:0]  light_2,
  output logic        sr_clk,
  output logic        sr_data,
  output logic        sr_latch,
  output logic        busy,
  output logic        frame_done
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]    DIV_TERM = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]    GAP_TERM = CNT_W'(GAP_CYC - 1);
  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(FRAME_W - 1);

  state_e               state_q;
  logic [FRAME_W-1:0]   shreg_q;
  logic [BITCNT_W-1:0]  bit_cnt_q;
  logic                 sr_clk_q, sr_data_q, sr_latch_q, busy_q, frame_done_q;
  logic                 tick, leave, clr;
  logic [CNT_W-1:0]     term;
  logic [FRAME_W-1:0]   frame_in;

  assign frame_in = pack_frame(light_2, light_1, outview);

  // Every exit is a state change, so the phase counter restarts on each one.
  always_comb begin
    term  = (state_q == ST_GAP) ? GAP_TERM : DIV_TERM;
    leave = tick;
    if (state_q == ST_IDLE) leave = en;
    if (state_q == ST_LOAD) leave = 1'b1;
    clr   = leave || (state_q == ST_IDLE);
  end

  view_ser_tick #(.W(CNT_W)) u_tick (
    .clk   (clk),
    .rst_n (rst),
    .clr   (clr),
    .term  (term),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      sr_clk_q     <= 1'b0;
      sr_data_q    <= 1'b0;
      sr_latch_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (leave) begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
          ST_LOAD: begin
            state_q   <= ST_SHIFT_LO;
            shreg_q   <= frame_in;
            bit_cnt_q <= '0;
            sr_data_q <= frame_in[FRAME_W-1];
          end
          ST_SHIFT_LO: begin
            state_q  <= ST_SHIFT_HI;
            sr_clk_q <= 1'b1;
          end
          ST_SHIFT_HI: begin
            shreg_q   <= {shreg_q[FRAME_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            sr_clk_q  <= 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              state_q    <= ST_LATCH;
              sr_data_q  <= 1'b0;
              sr_latch_q <= 1'b1;
            end else begin
              state_q   <= ST_SHIFT_LO;
              sr_data_q <= shreg_q[FRAME_W-2];
            end
          end
          ST_LATCH: begin
            state_q      <= ST_GAP;
            sr_latch_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
          ST_GAP: begin
            if (en) begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign sr_clk     = sr_clk_q;
  assign sr_data    = sr_data_q;
  assign sr_latch   = sr_latch_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_view_serializer.sv
// Directed bench for view_serializer: default-parameter and CLK_DIV=1/GAP_CYC=1 instances, frame scoreboard.
module tb_view_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_a, en_b;
  logic [17:0] outview;
  logic [3:0]  light_1, light_2;
  logic        sr_clk_a, sr_data_a, sr_latch_a, busy_a, frame_done_a;
  logic        sr_clk_b, sr_data_b, sr_latch_b, busy_b, frame_done_b;

  view_serializer dut_a (
    .clk(clk), .rst(rst), .en(en_a), .outview(outview), .light_1(light_1), .light_2(light_2),
    .sr_clk(sr_clk_a), .sr_data(sr_data_a), .sr_latch(sr_latch_a), .busy(busy_a),
    .frame_done(frame_done_a)
  );

  view_serializer #(.CLK_DIV(1), .GAP_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .outview(outview), .light_1(light_1), .light_2(light_2),
    .sr_clk(sr_clk_b), .sr_data(sr_data_b), .sr_latch(sr_latch_b), .busy(busy_b),
    .frame_done(frame_done_b)
  );

  logic sclk [2], sdat [2], slat [2], sfd [2];
  assign sclk[0] = sr_clk_a;     assign sclk[1] = sr_clk_b;
  assign sdat[0] = sr_data_a;    assign sdat[1] = sr_data_b;
  assign slat[0] = sr_latch_a;   assign slat[1] = sr_latch_b;
  assign sfd[0]  = frame_done_a; assign sfd[1]  = frame_done_b;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  logic [25:0] q_a[$];
  logic [25:0] q_b[$];

  logic [25:0] cap [2];
  int          nbits [2];
  int          rises [2];
  int          latches [2];
  int          lat_len [2];
  int          fd_cnt [2];
  int          fd_cyc [2];
  logic        pc [2];
  logic        pl [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: collect bits on sr_clk rises, score each frame at the latch strobe.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [25:0] e;
      int          div;
      div = (d == 0) ? 4 : 1;
      if (!rst) begin
        nbits[d]   = 0;
        lat_len[d] = 0;
        pc[d]      = 1'b0;
        pl[d]      = 1'b0;
      end else begin
        if (sclk[d] && !pc[d]) begin
          cap[d] = {cap[d][24:0], sdat[d]};
          nbits[d]++;
          rises[d]++;
        end
        if (slat[d]) lat_len[d]++;
        if (slat[d] && !pl[d]) begin
          latches[d]++;
          check($sformatf("bits_before_latch_%0d", d), nbits[d], 26);
          e = 'x;
          if (d == 0 && q_a.size() > 0) e = q_a.pop_front();
          if (d == 1 && q_b.size() > 0) e = q_b.pop_front();
          check($sformatf("frame_word_%0d", d), cap[d], e);
          nbits[d] = 0;
        end
        if (!slat[d] && pl[d]) begin
          check($sformatf("latch_width_%0d", d), lat_len[d], div);
          lat_len[d] = 0;
        end
        if (sfd[d]) begin
          fd_cnt[d]++;
          fd_cyc[d] = cyc;
        end
        pc[d] = sclk[d];
        pl[d] = slat[d];
      end
    end
  end

  task automatic wait_bits(input int d, input int n, input logic lvl, input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); #1;
      if (nbits[d] == n && sclk[d] == lvl) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic wait_fd(input int d, output int t);
    int  s;
    bit  ok;
    s  = fd_cnt[d];
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); #1;
      if (fd_cnt[d] != s) begin
        ok = 1'b1;
        break;
      end
    end
    check($sformatf("frame_done_seen_%0d", d), ok, 1'b1);
    t = fd_cyc[d];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, r0, l0;
    logic [19:0] tog;

    // 1: reset with random inputs, then idle with en=0
    rst = 1'b0; en_a = 1'($urandom); en_b = 1'($urandom);
    outview = 18'($urandom); light_1 = 4'($urandom); light_2 = 4'($urandom);
    repeat (3) @(negedge clk); #1;
    check("reset_outs_a", {sr_clk_a, sr_data_a, sr_latch_a, busy_a, frame_done_a}, 5'b0);
    check("reset_outs_b", {sr_clk_b, sr_data_b, sr_latch_b, busy_b, frame_done_b}, 5'b0);
    en_a = 1'b0; en_b = 1'b0; rst = 1'b1;
    repeat (20) @(negedge clk); #1;
    check("idle_outs_a", {sr_clk_a, sr_data_a, sr_latch_a, busy_a, frame_done_a}, 5'b0);
    check("idle_outs_b", {sr_clk_b, sr_data_b, sr_latch_b, busy_b, frame_done_b}, 5'b0);

    // 2: continuous refresh, frame word and period
    outview = 18'h2AAAA; light_1 = 4'hF; light_2 = 4'h0;
    repeat (3) q_a.push_back(26'h3EAAAA);
    en_a = 1'b1;
    wait_fd(0, t1);
    wait_fd(0, t2);
    check("period_a", t2 - t1, 229);

    // 3: input change mid-frame only affects later frames
    wait_bits(0, 11, 1'b1, "reach_bit10_hi");
    check("busy_mid_frame", busy_a, 1'b1);
    outview = 18'h00001;
    repeat (2) q_a.push_back(26'h3C0001);
    wait_fd(0, t1);
    wait_fd(0, t2);

    // 4: en dropped mid-frame completes the frame then idles
    wait_bits(0, 3, 1'b0, "reach_bit3_lo");
    en_a = 1'b0;
    wait_fd(0, t1);
    repeat (20) @(negedge clk); #1;
    check("idle_after_drop", {sr_clk_a, sr_data_a, sr_latch_a, busy_a, frame_done_a}, 5'b0);
    r0 = rises[0];
    repeat (300) @(negedge clk); #1;
    check("no_rises_when_idle", rises[0], r0);
    check("queue_a_drained", q_a.size(), 0);

    // 5: asynchronous reset mid-frame, then a clean frame
    outview = 18'h15555; light_1 = 4'h5; light_2 = 4'hA;
    en_a = 1'b1;
    wait_bits(0, 13, 1'b1, "reach_bit12_hi");
    l0 = latches[0];
    rst = 1'b0;
    #1;
    check("async_reset_outs", {sr_clk_a, sr_data_a, sr_latch_a, busy_a, frame_done_a}, 5'b0);
    repeat (3) @(negedge clk); #1;
    check("no_partial_latch", latches[0], l0);
    q_a.push_back({light_2, light_1, outview});
    rst = 1'b1;
    wait_bits(0, 1, 1'b1, "restart_first_bit");
    en_a = 1'b0;
    wait_fd(0, t1);
    check("one_latch_after_reset", latches[0], l0 + 1);
    check("queue_a_empty", q_a.size(), 0);

    // 6: fastest settings, sr_clk toggles every cycle, 55-cycle period
    q_b.push_back({light_2, light_1, outview});
    q_b.push_back({light_2, light_1, outview});
    en_b = 1'b1;
    wait_bits(1, 1, 1'b1, "b_first_rise");
    for (int i = 0; i < 20; i++) begin
      tog[i] = sr_clk_b;
      @(negedge clk); #1;
    end
    check("b_toggle_pattern", tog, 20'h55555);
    wait_fd(1, t1);
    wait_fd(1, t2);
    en_b = 1'b0;
    check("period_b", t2 - t1, 55);
    repeat (10) @(negedge clk); #1;
    check("b_idle_end", {sr_clk_b, sr_latch_b, busy_b}, 3'b0);
    check("queue_b_empty", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
